// File: rtl/ctrl_pkg.sv
// Shared state encodings, datapath select codes and control bundle type for the
// multicycle ARM-subset control unit.
package ctrl_pkg;

   localparam int STATE_ENC_W = 4;

   typedef enum logic [STATE_ENC_W-1:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9
   } statetype;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   typedef struct packed {
      logic       irwrite;
      logic       adrsrc;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] resultsrc;
      logic       nextpc;
      logic       regw;
      logic       memw;
      logic       branch;
      logic       aluop;
   } ctrl_t;

endpackage

// File: rtl/main_fsm_outdec.sv
// Moore output decode: maps the current state to the unqualified control bundle.
// Encodings outside the enum (10-15) decode to all-zero controls.
module main_fsm_outdec
   import ctrl_pkg::*;
(
   input  statetype state,
   output ctrl_t    ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         FETCH: begin
            ctrl.irwrite   = 1'b1;
            ctrl.adrsrc    = 1'b0;
            ctrl.alusrca   = 1'b1;
            ctrl.alusrcb   = SRCB_FOUR;
            ctrl.resultsrc = RES_ALURESULT;
            ctrl.nextpc    = 1'b1;
         end
         DECODE: begin
            ctrl.alusrca   = 1'b1;
            ctrl.alusrcb   = SRCB_FOUR;
            ctrl.resultsrc = RES_ALURESULT;
         end
         MEMADR: begin
            ctrl.alusrca = 1'b0;
            ctrl.alusrcb = SRCB_IMM;
         end
         MEMREAD: begin
            ctrl.adrsrc    = 1'b1;
            ctrl.resultsrc = RES_ALUOUT;
         end
         MEMWB: begin
            ctrl.resultsrc = RES_DATA;
            ctrl.regw      = 1'b1;
         end
         MEMWRITE: begin
            ctrl.adrsrc    = 1'b1;
            ctrl.resultsrc = RES_ALUOUT;
            ctrl.memw      = 1'b1;
         end
         EXECUTER: begin
            ctrl.alusrca = 1'b0;
            ctrl.alusrcb = SRCB_REG;
            ctrl.aluop   = 1'b1;
         end
         EXECUTEI: begin
            ctrl.alusrca = 1'b0;
            ctrl.alusrcb = SRCB_IMM;
            ctrl.aluop   = 1'b1;
         end
         ALUWB: begin
            ctrl.resultsrc = RES_ALUOUT;
            ctrl.regw      = 1'b1;
         end
         BRANCH: begin
            ctrl.alusrca   = 1'b0;
            ctrl.alusrcb   = SRCB_IMM;
            ctrl.resultsrc = RES_ALURESULT;
            ctrl.branch    = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/main_fsm.sv
// Multicycle main control FSM: fetch/decode/execute/writeback sequencing.
// Define MAIN_FSM_MEM_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE on mem_ready.
module main_fsm
   import ctrl_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         Op,
   input  logic [5:0]         Funct,
   input  logic               mem_ready,
   output logic               IRWrite,
   output logic               AdrSrc,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ResultSrc,
   output logic               NextPC,
   output logic               RegW,
   output logic               MemW,
   output logic               Branch,
   output logic               ALUOp,
   output logic [STATE_W-1:0] dbg_state
);

   statetype state_q;
   statetype state_d;
   ctrl_t    ctrl;
   logic     mem_go;

   // Only the S/L bit and the immediate bit steer the sequence.
   logic [3:0] unused_funct;
   assign unused_funct = Funct[4:1];

`ifdef MAIN_FSM_MEM_WAIT_EN
   assign mem_go = mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
   assign mem_go = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:    state_d = mem_go ? DECODE : FETCH;
         DECODE: begin
            case (Op)
               OP_MEM:  state_d = MEMADR;
               OP_DP:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
               OP_BR:   state_d = BRANCH;
               default: state_d = FETCH;
            endcase
         end
         MEMADR:   state_d = Funct[0] ? MEMREAD : MEMWRITE;
         MEMREAD:  state_d = mem_go ? MEMWB : MEMREAD;
         MEMWB:    state_d = FETCH;
         MEMWRITE: state_d = mem_go ? FETCH : MEMWRITE;
         EXECUTER: state_d = ALUWB;
         EXECUTEI: state_d = ALUWB;
         ALUWB:    state_d = FETCH;
         BRANCH:   state_d = FETCH;
         default:  state_d = FETCH;
      endcase
   end

   main_fsm_outdec u_outdec (
      .state (state_q),
      .ctrl  (ctrl)
   );

   // Side-effecting enables fire only on the cycle the access completes.
   assign IRWrite   = ctrl.irwrite & mem_go;
   assign NextPC    = ctrl.nextpc & mem_go;
   assign MemW      = ctrl.memw & mem_go;
   assign AdrSrc    = ctrl.adrsrc;
   assign ALUSrcA   = ctrl.alusrca;
   assign ALUSrcB   = ctrl.alusrcb;
   assign ResultSrc = ctrl.resultsrc;
   assign RegW      = ctrl.regw;
   assign Branch    = ctrl.branch;
   assign ALUOp     = ctrl.aluop;
   assign dbg_state = STATE_W'(state_q);

endmodule

// File: tb/tb_main_fsm.sv
// Randomized self-checking bench for main_fsm: per-instruction state paths and
// per-state output table derived from the instruction class, plus reset/illegal cases.
module tb_main_fsm;
   import ctrl_pkg::*;

`ifdef MAIN_FSM_MEM_WAIT_EN
   localparam bit WAIT_EN = 1'b1;
`else
   localparam bit WAIT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] Op = 2'b00;
   logic [5:0] Funct = 6'd0;
   logic       mem_ready = 1'b1;
   logic       IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, ALUOp;
   logic [1:0] ALUSrcB, ResultSrc;
   logic [3:0] dbg_state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   main_fsm #(.STATE_W(4)) dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
      .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
      .Branch(Branch), .ALUOp(ALUOp), .dbg_state(dbg_state)
   );

   // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,NextPC,RegW,MemW,Branch,ALUOp}
   function automatic logic [11:0] spec_out(input int st, input bit rdy);
      bit g;
      g = WAIT_EN ? rdy : 1'b1;
      case (st)
         0: spec_out = {g,    1'b0, 1'b1, 2'b10, 2'b10, g,    1'b0, 1'b0, 1'b0, 1'b0};
         1: spec_out = {1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
         2: spec_out = {1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
         3: spec_out = {1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
         4: spec_out = {1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
         5: spec_out = {1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, g,    1'b0, 1'b0};
         6: spec_out = {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
         7: spec_out = {1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
         8: spec_out = {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
         9: spec_out = {1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
         default: spec_out = 12'd0;
      endcase
   endfunction

   function automatic logic [11:0] obs_out();
      return {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp};
   endfunction

   task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Runs one instruction from FETCH. abort_at: pull reset while in that state.
   // illegal_at: overwrite the state register with 12 while in that state.
   // stall_state: hold mem_ready low for 3 visits of that state.
   task automatic run_instr(input logic [1:0] op, input logic [5:0] funct,
                            input int abort_at, input int illegal_at, input int stall_state);
      int path[$];
      bit rdy;
      bit hold;
      int stalls;
      path = {0, 1};
      case (op)
         2'b01: if (funct[0]) path = {path, 2, 3, 4}; else path = {path, 2, 5};
         2'b00: if (funct[5]) path = {path, 7, 8}; else path = {path, 6, 8};
         2'b10: path = {path, 9};
         default: ;
      endcase
      foreach (path[i]) begin
         stalls = 0;
         for (int k = 0; k < 8; k++) begin
            if (path[i] == 1 || path[i] == 2) begin
               Op = op;
               Funct = funct;
            end else begin
               Op = 2'($urandom_range(0, 3));
               Funct = 6'($urandom_range(0, 63));
            end
            if (path[i] == stall_state && stalls < 3) rdy = 1'b0;
            else if (stalls >= 4) rdy = 1'b1;
            else rdy = ($urandom_range(0, 3) != 0);
            mem_ready = rdy;
            #1;
            check($sformatf("op%0b_st%0d_state", op, path[i]), {8'd0, dbg_state}, 12'(path[i]));
            check($sformatf("op%0b_st%0d_outs", op, path[i]), obs_out(), spec_out(path[i], rdy));
            if (path[i] == abort_at) begin
               #1 reset = 1'b0;
               #1;
               check("async_reset_state", {8'd0, dbg_state}, 12'd0);
               check("async_reset_outs", obs_out(), spec_out(0, rdy));
               @(negedge clk);
               reset = 1'b1;
               return;
            end
            if (path[i] == illegal_at) begin
               #1 force dut.state_q = statetype'(4'd12);
               #1;
               check("illegal_state", {8'd0, dbg_state}, 12'd12);
               check("illegal_outs", obs_out(), 12'd0);
               #1 release dut.state_q;
            end
            hold = WAIT_EN && (path[i] == 0 || path[i] == 3 || path[i] == 5) && !rdy;
            @(negedge clk);
            if (!hold) break;
            stalls++;
         end
      end
   endtask

   initial begin
      logic [1:0] rop;
      logic [5:0] rfn;
      #1;
      check("reset_state", {8'd0, dbg_state}, 12'd0);
      check("reset_outs", obs_out(), spec_out(0, 1'b1));
      @(negedge clk);
      reset = 1'b1;
      // Directed: LDR, STR, ADD, immediate, branch, undefined.
      run_instr(2'b01, 6'b011001, -1, -1, -1);
      run_instr(2'b01, 6'b011000, -1, -1, -1);
      run_instr(2'b00, 6'b001000, -1, -1, -1);
      run_instr(2'b00, 6'b101000, -1, -1, -1);
      run_instr(2'b10, 6'b000000, -1, -1, -1);
      run_instr(2'b11, 6'b000000, -1, -1, -1);
      // Reset mid-MEMWB, then stalls in FETCH and MEMWRITE.
      run_instr(2'b01, 6'b011001, 4, -1, -1);
      run_instr(2'b00, 6'b001000, -1, -1, 0);
      run_instr(2'b01, 6'b011000, -1, -1, 5);
      run_instr(2'b01, 6'b011001, -1, -1, 3);
      // Illegal encoding injected while in BRANCH.
      run_instr(2'b10, 6'b010101, -1, 9, -1);
      for (int n = 0; n < 60; n++) begin
         rop = 2'($urandom_range(0, 3));
         rfn = 6'($urandom_range(0, 63));
         run_instr(rop, rfn, -1, -1, -1);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/main_fsm.md
Name: main_fsm

Overview:
- Multicycle control state machine for the ARM-subset processor.
- Sits inside the decoder, upstream of the condition logic.
- Takes Op and Funct from the instruction register and sequences each instruction through fetch, decode, execute and writeback.
- Outputs are the unconditioned enables (NextPC, RegW, MemW, Branch, IRWrite) plus the datapath mux selects; condition logic gates the enables, ALU decode consumes ALUOp.

Parameters:
- STATE_W, 4, width of the encoded state register and the dbg_state port.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]
- mem_ready  in  1  memory handshake; used only with MEM_WAIT_EN
- IRWrite  out  1  load instruction register
- AdrSrc  out  1  0 = PC address, 1 = ALU-result address
- ALUSrcA  out  1  0 = register A, 1 = PC
- ALUSrcB  out  2  00 = register B, 01 = ExtImm, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- NextPC  out  1  unconditional PC write (fetch)
- RegW  out  1  register write request
- MemW  out  1  memory write request
- Branch  out  1  branch request
- ALUOp  out  1  1 = ALU decode uses Funct; 0 = add
- dbg_state  out  STATE_W  current state encoding

Behaviour:
- Reset: reset low forces state to FETCH asynchronously, at any time, including mid-instruction; no partial instruction completes.
- Outputs are Moore: a pure decode of state, except the MEM_WAIT_EN qualification below.
- Reset output values are the FETCH outputs.
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9
  - 10-15 are illegal; next state = FETCH, all enables 0.
- Outputs per state (unlisted outputs are 0):
  - FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, NextPC=1
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10
  - MEMADR: ALUSrcA=0, ALUSrcB=01
  - MEMREAD: AdrSrc=1, ResultSrc=00
  - MEMWB: ResultSrc=01, RegW=1
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1
  - ALUWB: ResultSrc=00, RegW=1
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1
- Transitions:
  - FETCH -> DECODE
  - DECODE:
    - Op=01 -> MEMADR
    - Op=00 with Funct[5]=0 -> EXECUTER
    - Op=00 with Funct[5]=1 -> EXECUTEI
    - Op=10 -> BRANCH
    - Op=11 (undefined) -> FETCH, no side effects
  - MEMADR: Funct[0]=1 -> MEMREAD, else MEMWRITE
  - MEMREAD -> MEMWB -> FETCH
  - MEMWRITE -> FETCH
  - EXECUTER/EXECUTEI -> ALUWB -> FETCH
  - BRANCH -> FETCH
- Latency:
  - LDR 5 cycles; STR 4; data-processing 4; branch 3; undefined 2.
- Op and Funct are sampled only in DECODE and MEMADR; changes in other states are ignored.

Optional Feature:
- Macro: MAIN_FSM_MEM_WAIT_EN.
- Defined:
  - FETCH, MEMREAD and MEMWRITE hold while mem_ready=0.
  - IRWrite, NextPC (FETCH) and MemW (MEMWRITE) are asserted only in the cycle mem_ready=1, so the PC increments exactly once and the write happens once per access.
  - Other FETCH/MEMREAD/MEMWRITE outputs stay at their state values while waiting.
- Undefined: mem_ready is ignored; every state lasts exactly one cycle; port retained for a stable interface.

Decomposition:
- Shared package (ctrl_pkg) holds:
  - statetype enum with the encodings above
  - ALUSrcB and ResultSrc encoding localparams
  - Op localparams: OP_DP=00, OP_MEM=01, OP_BR=10
- Optional sub-module main_fsm_outdec: combinational state-to-control decode, kept separate so the verifier can check the output table in isolation.
- State register and next-state logic stay in main_fsm.

Test Plan:
- Reset: hold reset=0 mid-MEMWB, then release -> dbg_state=0; IRWrite=1, NextPC=1, ALUSrcB=10, RegW=0.
- LDR: Op=01, Funct=011001 -> state sequence 0,1,2,3,4,0; RegW=1 only in state 4 with ResultSrc=01; MemW never 1.
- STR and ADD:
  - STR: Op=01, Funct=011000 -> sequence 0,1,2,5,0; MemW=1 for exactly one cycle with AdrSrc=1.
  - ADD: Op=00, Funct=001000 -> sequence 0,1,6,8,0; ALUOp=1 in state 6; RegW=1 in state 8.
- Immediate and branch:
  - Immediate: Op=00, Funct=101000 -> state 7 with ALUSrcB=01.
  - Branch: Op=10 -> sequence 0,1,9,0; Branch=1 for one cycle.
  - Undefined: Op=11 -> sequence 0,1,0; no RegW/MemW/Branch.
- MAIN_FSM_MEM_WAIT_EN: mem_ready=0 for 3 cycles in FETCH -> state holds 0, IRWrite=NextPC=0; 4th cycle mem_ready=1 -> single IRWrite/NextPC pulse, then DECODE. Repeat for MEMWRITE: one MemW pulse.
- Illegal state: force state=12 -> next cycle dbg_state=0; all enables 0 during the illegal cycle.
